// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and width helpers for the fetch front end (feature macro: FETCH_RESP_ERR_EN)
package fetch_pkg;

    localparam int INST_BYTES = 4;

    // Width of a counter that must hold 0..n inclusive
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an index into n entries, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush (flush beats push and pop), used for in-flight PCs and the instruction buffer
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers and occupancy; flush empties the queue regardless of push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, written only by accepted pushes
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: multi-outstanding instruction fetch front end with redirect flush (feature macro: FETCH_RESP_ERR_EN adds response error tracking)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W          = 32,
    parameter int                XLEN            = 32,
    parameter int                MAX_OUTSTANDING = 2,
    parameter int                BUF_DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [XLEN-1:0]   imem_resp_data,
`ifdef FETCH_RESP_ERR_EN
    input  logic              imem_resp_err,
    output logic              inst_fault,
`endif
    output logic              imem_resp_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [XLEN-1:0]   inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int OCW = cnt_w(MAX_OUTSTANDING);
    localparam int BCW = cnt_w(BUF_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   data;
`ifdef FETCH_RESP_ERR_EN
        logic              fault;
`endif
    } fetch_entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [OCW-1:0]    outstanding;
    logic [OCW-1:0]    drop_cnt;
    logic [BCW-1:0]    buf_count;
    logic              if_full;
    logic              if_empty;
    logic              buf_full;
    logic              buf_empty;
    logic              req_fire;
    logic              resp_fire;
    logic              dropping;
    logic              resp_keep;
    logic              inst_fire;
    logic              stall;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    fetch_entry_t      hold;

    // Each request reserves a buffer slot, so responses can always be taken
    assign imem_resp_ready = !reset;
    assign imem_req_valid  = !reset && !redirect_valid && !if_full && !stall &&
                             (32'(outstanding) + 32'(buf_count) < BUF_DEPTH);
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign resp_fire       = imem_resp_valid && imem_resp_ready && !if_empty;
    assign dropping        = drop_cnt != '0;
    assign resp_keep       = resp_fire && !dropping && !redirect_valid;
    assign inst_valid      = !buf_empty && !redirect_valid;
    assign inst_fire       = inst_valid && inst_ready;
    assign inst_data       = inst_valid ? head.data : hold.data;
    assign inst_pc         = inst_valid ? head.pc : hold.pc;

    // Pair each returning word with the PC it was fetched from
    always_comb begin
        push_entry      = '0;
        push_entry.pc   = resp_pc;
        push_entry.data = imem_resp_data;
`ifdef FETCH_RESP_ERR_EN
        push_entry.fault = imem_resp_err;
`endif
    end

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_inflight (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .pop   (resp_fire),
        .flush (1'b0),
        .wdata (fetch_pc),
        .rdata (resp_pc),
        .count (outstanding),
        .full  (if_full),
        .empty (if_empty)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .push  (resp_keep),
        .pop   (inst_fire),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (head),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

`ifdef FETCH_RESP_ERR_EN
    logic err_take;
    assign err_take   = resp_keep && imem_resp_err;
    assign inst_fault = inst_valid ? head.fault : hold.fault;

    // After a faulting word is buffered, stop fetching until software redirects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall <= 1'b0;
        else if (redirect_valid) stall <= 1'b0;
        else if (err_take) stall <= 1'b1;
    end

    // Count in-flight responses that belong to an abandoned stream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt <= '0;
        else if (redirect_valid) drop_cnt <= outstanding - OCW'(resp_fire);
        else if (err_take) drop_cnt <= outstanding - OCW'(resp_fire) + OCW'(req_fire);
        else if (resp_fire && dropping) drop_cnt <= drop_cnt - 1'b1;
    end
`else
    assign stall = 1'b0;

    // Count in-flight responses that belong to an abandoned stream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt <= '0;
        else if (redirect_valid) drop_cnt <= outstanding - OCW'(resp_fire);
        else if (resp_fire && dropping) drop_cnt <= drop_cnt - 1'b1;
    end
`endif

    // Fetch PC advances on accepted requests and jumps on redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= redirect_pc;
        else if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(INST_BYTES);
    end

    // Remember the last presented entry so outputs hold while nothing is valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold <= '0;
        else if (inst_valid) hold <= head;
    end

    // Reservation and memory-protocol invariants
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (32'(outstanding) + 32'(buf_count) <= BUF_DEPTH);
            assert (!(imem_resp_valid && if_empty));
            assert (!(resp_keep && buf_full));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a programmable in-order instruction memory
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        imem_resp_err = 1'b0;
    logic        imem_resp_ready;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_RESP_ERR_EN
    logic        inst_fault;
`endif

    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    logic [31:0] mq[$];
    int          resp_cyc[logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          budget = 0;
    int          req_cnt = 0;
    int          max_out = 0;
    bit          mem_en = 1'b1;
    bit          lat_chk = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
`ifdef FETCH_RESP_ERR_EN
        .imem_resp_err   (imem_resp_err),
        .inst_fault      (inst_fault),
`endif
        .imem_resp_ready (imem_resp_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rst_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_resp_ready"}, imem_resp_ready, 0);
        chk({tag, "_inst_valid"}, inst_valid, 0);
        chk({tag, "_inst_data"}, inst_data, 0);
        chk({tag, "_inst_pc"}, inst_pc, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        rst_outputs(tag);
        step(2);
        reset = 1'b0;
    endtask

    // Queue n sequential request addresses from start, optionally also expecting them at decode
    task automatic expect_seq(input logic [31:0] start, input int n, input bit deliver);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = start + 32'(4 * i);
            req_q.push_back(a);
            if (deliver) exp_q.push_back('{a, a ^ K, 1'b0});
        end
    endtask

    task automatic drain(input string tag, input int lim);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || req_q.size() > 0) && k < lim) begin
            step();
            k++;
        end
        checks++;
        if (k >= lim) begin
            errors++;
            $display("FAIL %s_drain timeout pending_inst=%0d pending_req=%0d required=0", tag, exp_q.size(), req_q.size());
            exp_q.delete();
            req_q.delete();
        end
    endtask

    task automatic neg_chk(input string name, input logic [63:0] act, input logic [63:0] req);
        chk(name, act, req);
    endtask

    // Memory model: in-order, one-cycle latency when enabled; also checks request addresses
    initial begin
        bit          rf;
        bit          sf;
        logic [31:0] ra;
        forever begin
            @(negedge clk);
            rf = imem_req_valid && imem_req_ready;
            sf = imem_resp_valid && imem_resp_ready;
            ra = imem_req_addr;
            if (rf) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_addr unexpected actual=%0h required=none", ra);
                end else begin
                    chk("req_addr", ra, req_q.pop_front());
                end
            end
            if (sf && mq.size() > 0) resp_cyc[mq[0]] = cyc;
            @(posedge clk);
            #1;
            if (sf && mq.size() > 0) void'(mq.pop_front());
            if (rf) begin
                mq.push_back(ra);
                req_cnt++;
                budget--;
            end
            if (reset) mq.delete();
            if (mq.size() > max_out) max_out = mq.size();
            imem_req_ready  = budget > 0;
            imem_resp_valid = mem_en && mq.size() > 0 && !reset;
            imem_resp_data  = (mq.size() > 0) ? (mq[0] ^ K) : '0;
            imem_resp_err   = (mq.size() > 0) && (mq[0] == err_addr);
        end
    end

    // Decode-side monitor: pops the scoreboard on every accepted instruction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst unexpected actual_pc=%0h required=none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_data", inst_data, e.data);
`ifdef FETCH_RESP_ERR_EN
                    chk("inst_fault", inst_fault, e.fault);
`endif
                    if (lat_chk) chk("inst_latency", cyc - resp_cyc[inst_pc], 1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Streaming with a one-cycle memory
        budget = 6;
        inst_ready = 1'b1;
        expect_seq(32'h0, 6, 1'b1);
        lat_chk = 1'b1;
        do_reset("rst0");
        drain("stream", 60);
        lat_chk = 1'b0;
        step(2);
        @(negedge clk);
        neg_chk("hold_valid", inst_valid, 0);
        neg_chk("hold_pc", inst_pc, 32'h14);
        neg_chk("hold_data", inst_data, 32'h14 ^ K);
        step();

        // Decode stalled: only BUF_DEPTH requests may be issued
        budget = 6;
        inst_ready = 1'b0;
        expect_seq(32'h0, 6, 1'b1);
        do_reset("rst1");
        base = req_cnt;
        step(12);
        @(negedge clk);
        neg_chk("stall_req_count", req_cnt - base, 4);
        neg_chk("stall_req_valid", imem_req_valid, 0);
        step();
        inst_ready = 1'b1;
        drain("stall", 60);

        // Redirect with two outstanding and one buffered
        budget = 1;
        mem_en = 1'b1;
        inst_ready = 1'b0;
        expect_seq(32'h0, 1, 1'b0);
        do_reset("rst2");
        step(4);
        mem_en = 1'b0;
        budget = 2;
        expect_seq(32'h4, 2, 1'b0);
        step(4);
        @(negedge clk);
        neg_chk("pre_redirect_valid", inst_valid, 1);
        neg_chk("pre_redirect_pc", inst_pc, 32'h0);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        neg_chk("redirect_req_valid", imem_req_valid, 0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        neg_chk("flushed_inst_valid", inst_valid, 0);
        step();
        budget = 2;
        mem_en = 1'b1;
        inst_ready = 1'b1;
        expect_seq(32'h100, 2, 1'b1);
        drain("redirect", 60);
        chk("max_outstanding", max_out, 2);

        // Redirect in the same cycle as a response
        budget = 2;
        mem_en = 1'b0;
        inst_ready = 1'b1;
        expect_seq(32'h0, 2, 1'b0);
        do_reset("rst3");
        step(4);
        mem_en = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        neg_chk("same_cycle_resp_valid", imem_resp_valid && imem_resp_ready, 1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        neg_chk("drop_cnt", dut.drop_cnt, 1);
        step();
        budget = 2;
        expect_seq(32'h200, 2, 1'b1);
        drain("same_cycle", 60);

        // PC wrap, with redirect masking an otherwise issuable request
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        neg_chk("wrap_redirect_req_valid", imem_req_valid, 0);
        step();
        redirect_valid = 1'b0;
        budget = 2;
        req_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC ^ K, 1'b0});
        expect_seq(32'h0, 1, 1'b1);
        drain("wrap", 60);

        // Reset in the middle of a stream with buffered instructions
        inst_ready = 1'b0;
        budget = 2;
        expect_seq(32'h4, 2, 1'b0);
        step(6);
        @(negedge clk);
        neg_chk("mid_buffered_valid", inst_valid, 1);
        step();
        budget = 1;
        expect_seq(32'h0, 1, 1'b1);
        do_reset("rst_mid");
        inst_ready = 1'b1;
        drain("after_reset", 60);

`ifdef FETCH_RESP_ERR_EN
        // Erroring response stops fetch until a redirect
        err_addr = 32'h8;
        budget = 4;
        inst_ready = 1'b1;
        mem_en = 1'b1;
        expect_seq(32'h0, 2, 1'b1);
        req_q.push_back(32'h8);
        exp_q.push_back('{32'h8, 32'h8 ^ K, 1'b1});
        req_q.push_back(32'hC);
        do_reset("rst_err");
        drain("err", 60);
        budget = 2;
        base = req_cnt;
        step(6);
        @(negedge clk);
        neg_chk("err_stall_req_valid", imem_req_valid, 0);
        neg_chk("err_stall_req_count", req_cnt - base, 0);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        expect_seq(32'h40, 2, 1'b1);
        drain("err_resume", 60);
`endif

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
